// File: rtl/axis_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Package     : axis_fifo_pkg
// Description : Shared helpers for the multi-channel AXI-Stream FIFO address
//               generator: channel-select width function and packet-mode
//               encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_fifo_pkg;

    // Encodings for the PACKET_MODE parameter
    localparam int BEAT_MODE      = 0;
    localparam int PACKET_MODE_EN = 1;

    // Width of a channel select; a single channel still needs one bit
    function automatic int chan_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_axis_fifo_mc_chan_ptr.sv
`default_nettype none
// ============================================================================
// Module      : sync_axis_fifo_mc_chan_ptr
// Description : Pointer set for one FIFO channel. Holds write, commit and
//               read pointers (ADDRESS_WIDTH+1 bits, MSB is the wrap bit) and
//               derives write-side fill, committed level and status flags.
// Ports       : clk_i/rst_i      clock, async active-high reset
//               wr_inc_i         accepted write beat
//               commit_i         with wr_inc_i: expose everything up to it
//               drop_i           roll write pointer back to commit pointer
//               rd_inc_i         accepted read beat
//               waddr_o/raddr_o  in-region RAM offsets
//               fill_w_o/level_o write-side fill / committed level
//               full_o, almost_full_o, empty_o, almost_empty_o
// Revision    : 1.0 - initial release
// ============================================================================
module sync_axis_fifo_mc_chan_ptr #(
    parameter int ADDRESS_WIDTH          = 4,
    parameter int ALMOST_EMPTY_THRESHOLD = 4,
    parameter int ALMOST_FULL_THRESHOLD  = 4,
    localparam int PW                    = ADDRESS_WIDTH + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_inc_i,
    input  logic                     commit_i,
    input  logic                     drop_i,
    input  logic                     rd_inc_i,
    output logic [ADDRESS_WIDTH-1:0] waddr_o,
    output logic [ADDRESS_WIDTH-1:0] raddr_o,
    output logic [PW-1:0]            fill_w_o,
    output logic [PW-1:0]            level_o,
    output logic                     full_o,
    output logic                     almost_full_o,
    output logic                     empty_o,
    output logic                     almost_empty_o
);

    // May be negative when the threshold exceeds the depth: flag then always set
    localparam int AF_LIMIT = (2 ** ADDRESS_WIDTH) - ALMOST_FULL_THRESHOLD;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDRESS_WIDTH{1'b0}}};

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] cptr_q, cptr_d;
    logic [PW-1:0] rptr_q, rptr_d;

    always_comb begin
        wptr_d = wptr_q;
        cptr_d = cptr_q;
        rptr_d = rptr_q;
        if (drop_i) begin
            wptr_d = cptr_q;
        end else if (wr_inc_i) begin
            wptr_d = wptr_q + PW'(1);
            if (commit_i) begin
                cptr_d = wptr_q + PW'(1);
            end
        end
        if (rd_inc_i) begin
            rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            cptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            cptr_q <= cptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Modular subtraction keeps fill/level exact across any number of wraps
    assign fill_w_o = wptr_q - rptr_q;
    assign level_o  = cptr_q - rptr_q;

    assign waddr_o = wptr_q[ADDRESS_WIDTH-1:0];
    assign raddr_o = rptr_q[ADDRESS_WIDTH-1:0];

    assign full_o         = (fill_w_o == DEPTH);
    assign almost_full_o  = (int'(fill_w_o) > AF_LIMIT);
    assign empty_o        = (level_o == '0);
    assign almost_empty_o = (int'(level_o) < ALMOST_EMPTY_THRESHOLD);

endmodule
`default_nettype wire

// File: rtl/sync_axis_fifo_mc_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : sync_axis_fifo_mc_addr_gen
// Description : Single-clock multi-channel address generator for AXI-Stream
//               FIFOs sharing one simple-dual-port RAM, split into CHANNELS
//               regions of 2^ADDRESS_WIDTH entries. Optional packet mode
//               exposes data only after a last beat and supports dropping a
//               partially written packet.
// Ports       : aclk/areset                      clock, async active-high reset
//               s_axis_valid/ready/chan/last/drop write-side handshake
//               s_axis_wen/waddr                  RAM write port
//               s_axis_full/almost_full           per-channel write flags
//               m_axis_ready/chan/valid/raddr     read-side handshake/address
//               m_axis_empty/almost_empty/level   per-channel read status
// Revision    : 1.0 - initial release
// ============================================================================
module sync_axis_fifo_mc_addr_gen
    import axis_fifo_pkg::*;
#(
    parameter int ADDRESS_WIDTH          = 4,
    parameter int CHANNELS               = 4,
    parameter int ALMOST_EMPTY_THRESHOLD = 4,
    parameter int ALMOST_FULL_THRESHOLD  = 4,
    parameter int PACKET_MODE            = 0,
    localparam int CHAN_WIDTH            = chan_width(CHANNELS),
    localparam int PW                    = ADDRESS_WIDTH + 1
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic                              s_axis_valid,
    output logic                              s_axis_ready,
    input  logic [CHAN_WIDTH-1:0]             s_axis_chan,
    input  logic                              s_axis_last,
    input  logic                              s_axis_drop,
    output logic                              s_axis_wen,
    output logic [CHAN_WIDTH+ADDRESS_WIDTH-1:0] s_axis_waddr,
    output logic [CHANNELS-1:0]               s_axis_full,
    output logic [CHANNELS-1:0]               s_axis_almost_full,
    input  logic                              m_axis_ready,
    input  logic [CHAN_WIDTH-1:0]             m_axis_chan,
    output logic                              m_axis_valid,
    output logic [CHAN_WIDTH+ADDRESS_WIDTH-1:0] m_axis_raddr,
    output logic [CHANNELS-1:0]               m_axis_empty,
    output logic [CHANNELS-1:0]               m_axis_almost_empty,
    output logic [CHANNELS*PW-1:0]            m_axis_level
);

    localparam bit PKT_EN  = (PACKET_MODE == PACKET_MODE_EN);
    localparam bit BEAT_EN = (PACKET_MODE == BEAT_MODE);

    logic [ADDRESS_WIDTH-1:0] w_waddr [CHANNELS];
    logic [ADDRESS_WIDTH-1:0] w_raddr [CHANNELS];
    logic [PW-1:0]            w_level [CHANNELS];
    logic [CHANNELS*PW-1:0]   w_fill_unused;

    logic [CHANNELS-1:0] w_wr_inc;
    logic [CHANNELS-1:0] w_drop;
    logic [CHANNELS-1:0] w_rd_inc;

    logic                     w_s_in_range;
    logic                     w_m_in_range;
    logic                     w_pkt_drop;
    logic                     w_commit;
    logic                     w_drop_acc;
    logic                     w_full_sel;
    logic                     w_empty_sel;
    logic [ADDRESS_WIDTH-1:0] w_waddr_sel;
    logic [ADDRESS_WIDTH-1:0] w_raddr_sel;

    // Widened compare so a select equal to CHANNELS is rejected for any count
    assign w_s_in_range = ({1'b0, s_axis_chan} < (CHAN_WIDTH+1)'(CHANNELS));
    assign w_m_in_range = ({1'b0, m_axis_chan} < (CHAN_WIDTH+1)'(CHANNELS));

    assign w_pkt_drop = PKT_EN & s_axis_drop;
    assign w_commit   = BEAT_EN | s_axis_last;

    // Status muxes; an out-of-range select matches no channel and falls
    // through to the defaults (not full, empty, offset 0)
    always_comb begin
        w_full_sel  = 1'b0;
        w_empty_sel = 1'b1;
        w_waddr_sel = '0;
        w_raddr_sel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (s_axis_chan == CHAN_WIDTH'(c)) begin
                w_full_sel  = s_axis_full[c];
                w_waddr_sel = w_waddr[c];
            end
            if (m_axis_chan == CHAN_WIDTH'(c)) begin
                w_empty_sel = m_axis_empty[c];
                w_raddr_sel = w_raddr[c];
            end
        end
    end

    // A drop never writes RAM, so it is accepted even when the channel is full
    assign s_axis_ready = w_s_in_range & (w_pkt_drop | ~w_full_sel);
    assign s_axis_wen   = s_axis_valid & s_axis_ready & ~w_pkt_drop;
    assign w_drop_acc   = s_axis_valid & s_axis_ready & w_pkt_drop;
    assign s_axis_waddr = {s_axis_chan, w_waddr_sel};

    assign m_axis_valid = w_m_in_range & ~w_empty_sel;
    assign m_axis_raddr = {m_axis_chan, w_raddr_sel};

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
            assign w_wr_inc[c] = s_axis_wen & (s_axis_chan == CHAN_WIDTH'(c));
            assign w_drop[c]   = w_drop_acc & (s_axis_chan == CHAN_WIDTH'(c));
            assign w_rd_inc[c] = m_axis_ready & m_axis_valid &
                                 (m_axis_chan == CHAN_WIDTH'(c));

            sync_axis_fifo_mc_chan_ptr #(
                .ADDRESS_WIDTH          (ADDRESS_WIDTH),
                .ALMOST_EMPTY_THRESHOLD (ALMOST_EMPTY_THRESHOLD),
                .ALMOST_FULL_THRESHOLD  (ALMOST_FULL_THRESHOLD)
            ) u_chan_ptr (
                .clk_i          (aclk),
                .rst_i          (areset),
                .wr_inc_i       (w_wr_inc[c]),
                .commit_i       (w_commit),
                .drop_i         (w_drop[c]),
                .rd_inc_i       (w_rd_inc[c]),
                .waddr_o        (w_waddr[c]),
                .raddr_o        (w_raddr[c]),
                .fill_w_o       (w_fill_unused[c*PW +: PW]),
                .level_o        (w_level[c]),
                .full_o         (s_axis_full[c]),
                .almost_full_o  (s_axis_almost_full[c]),
                .empty_o        (m_axis_empty[c]),
                .almost_empty_o (m_axis_almost_empty[c])
            );

            assign m_axis_level[c*PW +: PW] = w_level[c];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_axis_fifo_mc_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_axis_fifo_mc_addr_gen
// Description : Self-checking bench. Two DUTs share one stimulus stream:
//               inst0 = beat mode, 4 channels; inst1 = packet mode, 3
//               channels (so select 3 is out of range). Expected values come
//               from per-channel counts: committed beats, pending (uncommitted)
//               beats and total beats read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_axis_fifo_mc_addr_gen;

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    logic       s_valid, s_last, s_drop, m_ready;
    logic [1:0] s_chan, m_chan;

    logic        a_ready, a_wen, a_mvalid;
    logic [5:0]  a_waddr, a_raddr;
    logic [3:0]  a_full, a_afull, a_empty, a_aempty;
    logic [19:0] a_level;

    logic        b_ready, b_wen, b_mvalid;
    logic [5:0]  b_waddr, b_raddr;
    logic [2:0]  b_full, b_afull, b_empty, b_aempty;
    logic [14:0] b_level;

    sync_axis_fifo_mc_addr_gen #(
        .ADDRESS_WIDTH(4), .CHANNELS(4), .ALMOST_EMPTY_THRESHOLD(4),
        .ALMOST_FULL_THRESHOLD(4), .PACKET_MODE(0)
    ) dut_a (
        .aclk(clk), .areset(areset),
        .s_axis_valid(s_valid), .s_axis_ready(a_ready), .s_axis_chan(s_chan),
        .s_axis_last(s_last), .s_axis_drop(s_drop), .s_axis_wen(a_wen),
        .s_axis_waddr(a_waddr), .s_axis_full(a_full), .s_axis_almost_full(a_afull),
        .m_axis_ready(m_ready), .m_axis_chan(m_chan), .m_axis_valid(a_mvalid),
        .m_axis_raddr(a_raddr), .m_axis_empty(a_empty),
        .m_axis_almost_empty(a_aempty), .m_axis_level(a_level)
    );

    sync_axis_fifo_mc_addr_gen #(
        .ADDRESS_WIDTH(4), .CHANNELS(3), .ALMOST_EMPTY_THRESHOLD(4),
        .ALMOST_FULL_THRESHOLD(4), .PACKET_MODE(1)
    ) dut_b (
        .aclk(clk), .areset(areset),
        .s_axis_valid(s_valid), .s_axis_ready(b_ready), .s_axis_chan(s_chan),
        .s_axis_last(s_last), .s_axis_drop(s_drop), .s_axis_wen(b_wen),
        .s_axis_waddr(b_waddr), .s_axis_full(b_full), .s_axis_almost_full(b_afull),
        .m_axis_ready(m_ready), .m_axis_chan(m_chan), .m_axis_valid(b_mvalid),
        .m_axis_raddr(b_raddr), .m_axis_empty(b_empty),
        .m_axis_almost_empty(b_aempty), .m_axis_level(b_level)
    );

    // Reference model: per instance / channel beat counts
    int lvl  [2][4];
    int pend [2][4];
    int rcnt [2][4];
    int nch  [2] = '{4, 3};
    bit pm   [2] = '{1'b0, 1'b1};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic model_reset();
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 4; c++) begin
                lvl[i][c] = 0; pend[i][c] = 0; rcnt[i][c] = 0;
            end
    endtask

    // One clock cycle: drive, compare every output of both DUTs against the
    // model, clock, then advance the model. Called at posedge+1.
    task automatic step(input bit v, input bit [1:0] ch, input bit last,
                        input bit drop, input bit rd, input bit [1:0] rch);
        bit          inr, minr, e_ready, e_wen, e_mvalid;
        bit          acc_w [2];
        bit          acc_d [2];
        bit          acc_r [2];
        int          fill, f;
        logic [5:0]  e_waddr, e_raddr, g_waddr, g_raddr;
        logic [3:0]  e_full, e_afull, e_empty, e_aempty;
        logic [3:0]  g_full, g_afull, g_empty, g_aempty;
        logic [19:0] e_level, g_level;
        logic        g_ready, g_wen, g_mvalid;
        s_valid = v; s_chan = ch; s_last = last; s_drop = drop;
        m_ready = rd; m_chan = rch;
        #1;
        for (int i = 0; i < 2; i++) begin
            inr      = (int'(ch) < nch[i]);
            minr     = (int'(rch) < nch[i]);
            fill     = lvl[i][ch] + pend[i][ch];
            e_ready  = inr && ((pm[i] && drop) || fill != 16);
            e_wen    = v && e_ready && !(pm[i] && drop);
            acc_w[i] = e_wen;
            acc_d[i] = v && e_ready && pm[i] && drop;
            e_waddr  = {ch, 4'((rcnt[i][ch] + fill) % 16)};
            e_mvalid = minr && (lvl[i][rch] > 0);
            acc_r[i] = rd && e_mvalid;
            e_raddr  = {rch, 4'(rcnt[i][rch] % 16)};
            e_full = '0; e_afull = '0; e_empty = '0; e_aempty = '0; e_level = '0;
            for (int c = 0; c < nch[i]; c++) begin
                f = lvl[i][c] + pend[i][c];
                e_full[c]          = (f == 16);
                e_afull[c]         = (f > 16 - 4);
                e_empty[c]         = (lvl[i][c] == 0);
                e_aempty[c]        = (lvl[i][c] < 4);
                e_level[c*5 +: 5]  = 5'(lvl[i][c]);
            end
            g_ready  = (i == 0) ? a_ready  : b_ready;
            g_wen    = (i == 0) ? a_wen    : b_wen;
            g_waddr  = (i == 0) ? a_waddr  : b_waddr;
            g_mvalid = (i == 0) ? a_mvalid : b_mvalid;
            g_raddr  = (i == 0) ? a_raddr  : b_raddr;
            g_full   = (i == 0) ? a_full   : {1'b0, b_full};
            g_afull  = (i == 0) ? a_afull  : {1'b0, b_afull};
            g_empty  = (i == 0) ? a_empty  : {1'b0, b_empty};
            g_aempty = (i == 0) ? a_aempty : {1'b0, b_aempty};
            g_level  = (i == 0) ? a_level  : {5'd0, b_level};

            n_checks++;
            if (g_ready !== e_ready)
                $display("FAIL s_axis_ready inst%0d t=%0t: got %b need %b", i, $time, g_ready, e_ready);
            else n_pass++;
            n_checks++;
            if (g_wen !== e_wen)
                $display("FAIL s_axis_wen inst%0d t=%0t: got %b need %b", i, $time, g_wen, e_wen);
            else n_pass++;
            if (inr) begin
                n_checks++;
                if (g_waddr !== e_waddr)
                    $display("FAIL s_axis_waddr inst%0d t=%0t: got %h need %h", i, $time, g_waddr, e_waddr);
                else n_pass++;
            end
            n_checks++;
            if (g_mvalid !== e_mvalid)
                $display("FAIL m_axis_valid inst%0d t=%0t: got %b need %b", i, $time, g_mvalid, e_mvalid);
            else n_pass++;
            if (minr) begin
                n_checks++;
                if (g_raddr !== e_raddr)
                    $display("FAIL m_axis_raddr inst%0d t=%0t: got %h need %h", i, $time, g_raddr, e_raddr);
                else n_pass++;
            end
            n_checks++;
            if (g_full !== e_full)
                $display("FAIL full inst%0d t=%0t: got %b need %b", i, $time, g_full, e_full);
            else n_pass++;
            n_checks++;
            if (g_afull !== e_afull)
                $display("FAIL almost_full inst%0d t=%0t: got %b need %b", i, $time, g_afull, e_afull);
            else n_pass++;
            n_checks++;
            if (g_empty !== e_empty)
                $display("FAIL empty inst%0d t=%0t: got %b need %b", i, $time, g_empty, e_empty);
            else n_pass++;
            n_checks++;
            if (g_aempty !== e_aempty)
                $display("FAIL almost_empty inst%0d t=%0t: got %b need %b", i, $time, g_aempty, e_aempty);
            else n_pass++;
            n_checks++;
            if (g_level !== e_level)
                $display("FAIL level inst%0d t=%0t: got %h need %h", i, $time, g_level, e_level);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (acc_r[i]) begin
                lvl[i][rch]--;
                rcnt[i][rch]++;
            end
            if (acc_w[i]) begin
                if (!pm[i] || last) begin
                    lvl[i][ch] += pend[i][ch] + 1;
                    pend[i][ch] = 0;
                end else begin
                    pend[i][ch]++;
                end
            end
            if (acc_d[i]) pend[i][ch] = 0;
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        model_reset();
        step(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (a_empty !== 4'hF || b_empty !== 3'h7)
            $display("FAIL reset_empty: got %b/%b need 1111/111", a_empty, b_empty);
        else n_pass++;
        n_checks++;
        if (a_level !== 20'd0 || b_level !== 15'd0 || a_full !== 4'h0)
            $display("FAIL reset_level: got %h/%h full %b need 0", a_level, b_level, a_full);
        else n_pass++;
        areset = 1'b0;
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_fill_ch0();
        for (int k = 0; k < 17; k++) step(1, 0, 0, 0, 0, 0);
        n_checks++;
        if (a_full !== 4'b0001)
            $display("FAIL fill_full: got %b need 0001", a_full);
        else n_pass++;
        n_checks++;
        if (a_level[4:0] !== 5'd16)
            $display("FAIL fill_level: got %0d need 16", a_level[4:0]);
        else n_pass++;
    endtask

    task automatic test_interleave();
        for (int k = 0; k < 60; k++) begin
            step(1'($urandom), 2'((k % 2) + 1), 1'($urandom_range(0, 2) == 0),
                 0, 1'($urandom), 2'd2);
        end
        // Simultaneous write and read on ch2 keep its level unchanged
        for (int k = 0; k < 6; k++) step(1, 2, 1, 0, 1, 2);
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 40; k++) step(1, 3, 0, 0, 1, 3);
    endtask

    task automatic test_async_reset();
        step(1, 1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        s_valid = 1'b0;
        areset  = 1'b1;
        #1;
        n_checks++;
        if (a_empty !== 4'hF || b_empty !== 3'h7 || a_mvalid !== 1'b0)
            $display("FAIL async_empty: got %b/%b valid %b need 1111/111/0", a_empty, b_empty, a_mvalid);
        else n_pass++;
        n_checks++;
        if (a_level !== 20'd0 || b_level !== 15'd0)
            $display("FAIL async_level: got %h/%h need 0", a_level, b_level);
        else n_pass++;
        model_reset();
        @(posedge clk);
        #2;
        areset = 1'b0;
        s_valid = 1'b1; s_chan = 2'd1;
        #1;
        n_checks++;
        if (a_waddr !== 6'h10 || b_waddr !== 6'h10)
            $display("FAIL async_first_waddr: got %h/%h need 10", a_waddr, b_waddr);
        else n_pass++;
        step(1, 1, 1, 0, 0, 0);
    endtask

    task automatic test_packet();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 1, 0, 1, 0);
        n_checks++;
        if (b_level[4:0] !== 5'd3 || b_mvalid !== 1'b1)
            $display("FAIL pkt_commit: got level %0d valid %b need 3/1", b_level[4:0], b_mvalid);
        else n_pass++;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_out_of_range();
        for (int k = 0; k < 4; k++) step(1, 3, 1, 1'(k % 2), 1, 3);
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom), 2'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 7) == 0), 1'($urandom), 2'($urandom));
        end
    endtask

    initial begin
        areset = 1'b1;
        s_valid = 0; s_chan = 0; s_last = 0; s_drop = 0; m_ready = 0; m_chan = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_fill_ch0();
        test_interleave();
        test_wrap();
        test_async_reset();
        test_packet();
        test_out_of_range();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
